// File: rtl/rast_ctrl_pkg.sv
// rast_ctrl_pkg: shared state encoding and helpers
// for the rasterizer sample-iteration control path.
package rast_ctrl_pkg;

  typedef enum logic {
    WAIT_STATE = 1'b0,
    TEST_STATE = 1'b1
  } state_t;

  function automatic logic [1:0] ss_decode(
    input logic [3:0] ss
  );
    logic [1:0] lg2;
    lg2 = 2'd0;
    unique case (1'b1)
      ss[0]:   lg2 = 2'd3;
      ss[1]:   lg2 = 2'd2;
      ss[2]:   lg2 = 2'd1;
      ss[3]:   lg2 = 2'd0;
      default: lg2 = 2'd0;
    endcase
    return lg2;
  endfunction

  function automatic bit samps_ok(input int s);
    return (s == 1) || (s == 2) || (s == 4) || (s == 8);
  endfunction

endpackage

// File: rtl/dff.sv
// dff: enabled register cell with asynchronous
// active-low clear, used for every pipeline flop.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // clear on reset, load only when enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/smpl_lane_gen.sv
// smpl_lane_gen: expands a cursor into SAMPS lane
// sample positions plus the in-box valid mask.
module smpl_lane_gen #(
  parameter int SIGFIG = 24,
  parameter int SAMPS  = 4
) (
  input  logic [SIGFIG-1:0]                 cur_x,
  input  logic [SIGFIG-1:0]                 cur_y,
  input  logic [SIGFIG-1:0]                 step,
  input  logic [SIGFIG-1:0]                 ur_x,
  output logic [SAMPS-1:0][1:0][SIGFIG-1:0] lane,
  output logic [SAMPS-1:0]                  mask
);

  logic signed [SIGFIG:0] cx_e;
  logic signed [SIGFIG:0] st_e;
  logic signed [SIGFIG:0] ur_e;
  logic signed [SIGFIG:0] lx [SAMPS];

  assign cx_e = {cur_x[SIGFIG-1], cur_x};
  assign st_e = {1'b0, step};
  assign ur_e = {ur_x[SIGFIG-1], ur_x};

  // lane i sits i steps right of the cursor; valid while inside the box
  always_comb begin
    for (int i = 0; i < SAMPS; i++) begin
      lx[i]      = cx_e + st_e * (SIGFIG+1)'(i);
      lane[i][0] = lx[i][SIGFIG-1:0];
      lane[i][1] = cur_y;
      mask[i]    = lx[i] <= ur_e;
    end
  end

endmodule

// File: rtl/smpl_iter_ctrl.sv
// smpl_iter_ctrl: walks a triangle's sample box in
// raster order, SAMPS lanes per cycle, with halt flow control.
module smpl_iter_ctrl
  import rast_ctrl_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]        color_R13U,
  input  logic                                 validTri_R13H,
  input  logic [1:0][1:0][SIGFIG-1:0]          box_R13S,
  input  logic [3:0]                           subSample_RnnnnU,
  input  logic                                 halt_RnnnnL,
  output logic                                 halt_R13L,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]        color_R14U,
  output logic [SAMPS-1:0][1:0][SIGFIG-1:0]    sample_R14S,
  output logic [SAMPS-1:0]                     validSamp_R14H
);

  localparam int LG_SAMPS = $clog2(SAMPS);
  localparam int TW = VERTS * AXIS * SIGFIG;
  localparam int KW = COLORS * SIGFIG;
  localparam int LW = SAMPS * 2 * SIGFIG;
  localparam int CW = 1 + 6 * SIGFIG;
  localparam int OW = TW + KW + LW + SAMPS;

  if (!samps_ok(SAMPS)) begin : g_bad_samps
    $error("SAMPS must be 1, 2, 4 or 8");
  end

  state_t state;
  state_t nxt_state;
  logic   st_bit;

  logic [SIGFIG-1:0] cur_x, cur_y, ll_x;
  logic [SIGFIG-1:0] ur_x, ur_y, step;
  logic [SIGFIG-1:0] nxt_cx, nxt_cy, nxt_llx;
  logic [SIGFIG-1:0] nxt_urx, nxt_ury, nxt_step;
  logic [SIGFIG-1:0] in_step;

  logic signed [SIGFIG:0] adv_x, adv_y;
  logic signed [SIGFIG:0] urx_e, ury_e;
  logic x_end, y_end, last_group;
  logic accept, emit;

  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] nxt_tri;
  logic [COLORS-1:0][SIGFIG-1:0]          nxt_col;
  logic [SAMPS-1:0][1:0][SIGFIG-1:0]      lane;
  logic [SAMPS-1:0]                       mask;

  logic [CW-1:0] ctl_d, ctl_q;
  logic [OW-1:0] out_d, out_q;

  assign {st_bit, cur_x, cur_y, ll_x,
          ur_x, ur_y, step} = ctl_q;
  assign state = state_t'(st_bit);

  assign in_step = SIGFIG'(1) <<
    (RADIX - int'(ss_decode(subSample_RnnnnU)));

  assign adv_x = {cur_x[SIGFIG-1], cur_x} +
                 ({1'b0, step} << LG_SAMPS);
  assign adv_y = {cur_y[SIGFIG-1], cur_y} +
                 {1'b0, step};
  assign urx_e = {ur_x[SIGFIG-1], ur_x};
  assign ury_e = {ur_y[SIGFIG-1], ur_y};

  assign x_end      = adv_x > urx_e;
  assign y_end      = adv_y > ury_e;
  assign last_group = x_end && y_end;

  assign halt_R13L = halt_RnnnnL &&
    (state == WAIT_STATE || last_group);
  assign accept = validTri_R13H && halt_R13L;

  // next cursor, box latch and state; accept wins over walk
  always_comb begin
    nxt_state = state;
    nxt_cx    = cur_x;
    nxt_cy    = cur_y;
    nxt_llx   = ll_x;
    nxt_urx   = ur_x;
    nxt_ury   = ur_y;
    nxt_step  = step;
    nxt_tri   = tri_R14S;
    nxt_col   = color_R14U;
    emit      = 1'b0;
    if (accept) begin
      nxt_state = TEST_STATE;
      nxt_cx    = box_R13S[0][0];
      nxt_cy    = box_R13S[0][1];
      nxt_llx   = box_R13S[0][0];
      nxt_urx   = box_R13S[1][0];
      nxt_ury   = box_R13S[1][1];
      nxt_step  = in_step;
      nxt_tri   = tri_R13S;
      nxt_col   = color_R13U;
      emit      = 1'b1;
    end else if (state == TEST_STATE) begin
      if (last_group) begin
        nxt_state = WAIT_STATE;
      end else begin
        emit = 1'b1;
        if (!x_end) begin
          nxt_cx = adv_x[SIGFIG-1:0];
        end else begin
          nxt_cx = ll_x;
          nxt_cy = adv_y[SIGFIG-1:0];
        end
      end
    end
  end

  smpl_lane_gen #(
    .SIGFIG (SIGFIG),
    .SAMPS  (SAMPS)
  ) u_lane (
    .cur_x (nxt_cx),
    .cur_y (nxt_cy),
    .step  (nxt_step),
    .ur_x  (nxt_urx),
    .lane  (lane),
    .mask  (mask)
  );

  assign ctl_d = {nxt_state, nxt_cx, nxt_cy, nxt_llx,
                  nxt_urx, nxt_ury, nxt_step};
  assign out_d = {nxt_tri, nxt_col, lane,
                  {SAMPS{emit}} & mask};

  dff #(.W(CW)) u_ctl (
    .clk (clk),
    .rst (rst),
    .en  (halt_RnnnnL),
    .d   (ctl_d),
    .q   (ctl_q)
  );

  dff #(.W(OW)) u_r14 (
    .clk (clk),
    .rst (rst),
    .en  (halt_RnnnnL),
    .d   (out_d),
    .q   (out_q)
  );

  assign {tri_R14S, color_R14U,
          sample_R14S, validSamp_R14H} = out_q;

endmodule

// File: tb/tb_smpl_iter_ctrl.sv
// tb_smpl_iter_ctrl: directed vectors with a scoreboard
// queue; a negedge monitor pops and checks each group.
module tb_smpl_iter_ctrl;

  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int SAMPS  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
  logic                                   validTri_R13H;
  logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
  logic [3:0]                             subSample_RnnnnU;
  logic                                   halt_RnnnnL;
  logic                                   halt_R13L;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
  logic [SAMPS-1:0][1:0][SIGFIG-1:0]      sample_R14S;
  logic [SAMPS-1:0]                       validSamp_R14H;

  smpl_iter_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_R13S),
    .color_R13U       (color_R13U),
    .validTri_R13H    (validTri_R13H),
    .box_R13S         (box_R13S),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnL      (halt_RnnnnL),
    .halt_R13L        (halt_R13L),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .sample_R14S      (sample_R14S),
    .validSamp_R14H   (validSamp_R14H)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               x;
    int               y;
    int               step;
    logic [SAMPS-1:0] mask;
    int               tag;
    bit               contig;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_pop = -10;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name,
                     input longint act,
                     input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // consume a group whenever the DUT presents one and downstream takes it
  always @(negedge clk) begin : mon
    exp_t e;
    bit   ok;
    if (rst && halt_RnnnnL && validSamp_R14H != '0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_group: got mask %b cyc %0d want none",
                 validSamp_R14H, cyc);
      end else begin
        e = exp_q.pop_front();
        ok = (validSamp_R14H == e.mask) &&
             (tri_R14S[0][0] == 24'(e.tag)) &&
             (color_R14U[0] == 24'(e.tag + 1));
        for (int i = 0; i < SAMPS; i++) begin
          if (sample_R14S[i][0] != 24'(e.x + i * e.step)) ok = 1'b0;
          if (sample_R14S[i][1] != 24'(e.y)) ok = 1'b0;
        end
        if (e.contig && cyc != last_pop + 1) ok = 1'b0;
        if (!ok) begin
          bad++;
          $display("FAIL group tag=%0d: got x0=%0d y=%0d mask=%b tag=%0d cyc=%0d want x0=%0d y=%0d mask=%b contig=%0d last=%0d",
                   e.tag, $signed(sample_R14S[0][0]),
                   $signed(sample_R14S[0][1]), validSamp_R14H,
                   tri_R14S[0][0], cyc, e.x, e.y, e.mask,
                   e.contig, last_pop);
        end
        last_pop = cyc;
      end
    end
  end

  task automatic push_groups(input int llx, input int lly,
                             input int urx, input int ury,
                             input int lg, input int tag,
                             input bit fc, input bit gap,
                             input int limit);
    int   st;
    int   n;
    exp_t e;
    st = 1 << (10 - lg);
    n = 0;
    for (int y = lly; y <= ury; y += st) begin
      for (int x = llx; x <= urx; x += SAMPS * st) begin
        e.x = x;
        e.y = y;
        e.step = st;
        e.tag = tag;
        e.contig = (n == 0) ? fc : gap;
        for (int i = 0; i < SAMPS; i++)
          e.mask[i] = (x + i * st) <= urx;
        if (n < limit) exp_q.push_back(e);
        n++;
      end
    end
  endtask

  task automatic tri_go(input int llx, input int lly,
                        input int urx, input int ury,
                        input int lg, input int tag,
                        input bit fc, input bit gap,
                        input int limit);
    int n;
    push_groups(llx, lly, urx, ury, lg, tag, fc, gap, limit);
    tri_R13S = '0;
    tri_R13S[0][0] = 24'(tag);
    tri_R13S[2][2] = 24'(tag * 7);
    color_R13U = '0;
    color_R13U[0] = 24'(tag + 1);
    box_R13S[0][0] = 24'(llx);
    box_R13S[0][1] = 24'(lly);
    box_R13S[1][0] = 24'(urx);
    box_R13S[1][1] = 24'(ury);
    subSample_RnnnnU = 4'(1 << (3 - lg));
    validTri_R13H = 1'b1;
    n = 0;
    @(negedge clk);
    while (!halt_R13L && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!halt_R13L) begin
      total++;
      bad++;
      $display("FAIL accept_timeout tag=%0d: got no accept want accept", tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tri_R13S = '0;
    color_R13U = '0;
    validTri_R13H = 1'b0;
    box_R13S = '0;
    subSample_RnnnnU = 4'b1000;
    halt_RnnnnL = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_valid", validSamp_R14H, 0);
    chk("rst_sample", |sample_R14S, 0);
    chk("rst_tri_col", |{tri_R14S, color_R14U}, 0);
    chk("rst_halt_hi", halt_R13L, 1);
    halt_RnnnnL = 1'b0;
    #1;
    chk("rst_halt_lo", halt_R13L, 0);
    halt_RnnnnL = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;

    tri_go(0, 0, 3072, 1024, 0, 1, 0, 1, 99);
    validTri_R13H = 1'b0;
    @(negedge clk);
    chk("t1_first_valid", validSamp_R14H, 4'hf);
    chk("t1_halt_busy", halt_R13L, 0);
    @(negedge clk);
    chk("t1_halt_last", halt_R13L, 1);
    @(negedge clk);
    chk("t1_wait_idle", validSamp_R14H, 0);
    chk("t1_wait_ready", halt_R13L, 1);
    drain();

    tri_go(0, 0, 4096, 0, 0, 2, 0, 1, 99);
    validTri_R13H = 1'b0;
    drain();

    tri_go(0, 0, 256, 256, 2, 3, 0, 1, 99);
    validTri_R13H = 1'b0;
    drain();

    tri_go(0, 0, 3072, 3072, 0, 4, 0, 0, 99);
    validTri_R13H = 1'b0;
    @(posedge clk);
    #1;
    halt_RnnnnL = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_stall_x3", sample_R14S[3][0], 3072);
      chk("t4_stall_y", sample_R14S[0][1], 1024);
      chk("t4_stall_mask", validSamp_R14H, 4'hf);
      chk("t4_stall_halt", halt_R13L, 0);
      @(posedge clk);
    end
    #1;
    halt_RnnnnL = 1'b1;
    drain();

    tri_go(0, 0, 1024, 0, 0, 5, 0, 1, 99);
    tri_go(2048, 1024, 6144, 1024, 0, 6, 1, 1, 99);
    validTri_R13H = 1'b0;
    drain();

    tri_go(5120, 2048, 5120, 2048, 3, 7, 0, 1, 99);
    validTri_R13H = 1'b0;
    drain();

    tri_go(-2048, -1024, 2048, -1024, 0, 8, 0, 1, 99);
    validTri_R13H = 1'b0;
    drain();

    tri_go(0, 0, 3072, 5120, 0, 9, 0, 1, 1);
    validTri_R13H = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t8_rst_valid", validSamp_R14H, 0);
    chk("t8_rst_sample", |sample_R14S, 0);
    chk("t8_rst_tri", |{tri_R14S, color_R14U}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t8_post_valid", validSamp_R14H, 0);
    chk("t8_post_ready", halt_R13L, 1);
    chk("t8_dropped", exp_q.size(), 0);
    @(posedge clk);
    #1;
    tri_go(1024, 1024, 1024, 1024, 3, 10, 0, 1, 99);
    validTri_R13H = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
